vend_txn_controller: RTL

Transaction sequencer for the vending machine. It accepts coins one at a time over a valid/ready handshake and holds the running credit. It validates a product selection against a fixed price table and drives the dispenser over a valid/ack handshake. It then pays out change one coin per handshake, largest denomination first. It sits between the coin acceptor, keypad, product dispenser and coin hopper, and replaces the single-cycle lump-sum change computation with a sequenced, back-pressurable flow.

---
 rtl/vend_txn_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/vend_txn_controller.sv
// vend_txn_controller: coin collection, price check, vend handshake and coin-by-coin change payout
module vend_txn_controller #(
  parameter int unsigned MAX_CREDIT = 200,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  output logic       coin_ready,
  output logic       coin_reject,
  input  logic       select_valid,
  input  logic [2:0] selection,
  output logic       select_ready,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       vend_valid,
  output logic [2:0] item,
  input  logic       vend_ack,
  output logic       change_valid,
  output logic [1:0] change_type,
  input  logic       change_ack,
  output logic [1:0] status
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ST_OK = 2'd0, ST_INSUF = 2'd1, ST_INVAL = 2'd2, ST_TMO = 2'd3;
  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;
  state_t state_q, state_d;
  logic [7:0] credit_q, credit_d, change_q, change_d, price, pay_val;
  logic [2:0] item_q, item_d;
  logic [1:0] status_q, status_d;
  logic reject_q, reject_d, sel_ok;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [8:0] coin_val, sum;
  assign coin_val = coin_type == 2'd0 ? 9'd5 : coin_type == 2'd1 ? 9'd10 : coin_type == 2'd2 ? 9'd25 : 9'd100;
  assign sum = {1'b0, credit_q} + coin_val;
  assign sel_ok = selection < 3'd6;
  assign price = selection == 3'd0 ? 8'd100 : selection == 3'd1 ? 8'd85 : selection == 3'd2 ? 8'd75 :
                 selection == 3'd3 ? 8'd50 : selection == 3'd4 ? 8'd25 : selection == 3'd5 ? 8'd15 : 8'd0;
  assign change_type = change_q >= 8'd100 ? 2'd3 : change_q >= 8'd25 ? 2'd2 : change_q >= 8'd10 ? 2'd1 : 2'd0;
  assign pay_val = change_type == 2'd3 ? 8'd100 : change_type == 2'd2 ? 8'd25 : change_type == 2'd1 ? 8'd10 : 8'd5;
  assign select_ready = state_q == COLLECT && !cancel;
  assign coin_ready = state_q == COLLECT && !cancel && !select_valid;
  assign vend_valid = state_q == VEND;
  assign change_valid = state_q == CHANGE;
  assign credit = state_q == CHANGE ? change_q : credit_q;
  assign item = item_q;
  assign status = status_q;
  assign coin_reject = reject_q;
  always_ff @(posedge clock)
    if (reset) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      change_q <= '0;
      item_q   <= '0;
      status_q <= ST_OK;
      reject_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      item_q   <= item_d;
      status_q <= status_d;
      reject_q <= reject_d;
      tmo_q    <= tmo_d;
    end
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    item_d   = item_q;
    status_d = status_q;
    reject_d = 1'b0;
    tmo_d    = tmo_q;
    case (state_q)
      COLLECT:
        if (cancel) begin
          tmo_d = '0;
          if (credit_q != 8'd0) begin
            change_d = credit_q;
            credit_d = '0;
            state_d  = CHANGE;
          end
        end else if (select_valid) begin
          tmo_d = '0;
          if (!sel_ok) status_d = ST_INVAL;
          else if (credit_q < price) status_d = ST_INSUF;
          else begin
            item_d   = selection;
            change_d = credit_q - price;
            status_d = ST_OK;
            state_d  = VEND;
          end
        end else if (coin_valid) begin
          tmo_d = '0;
          if (sum <= 9'(MAX_CREDIT)) begin
            credit_d = sum[7:0];
            status_d = ST_OK;
          end else reject_d = 1'b1;
        end else if (credit_q == 8'd0) tmo_d = '0;
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_d    = '0;
          status_d = ST_TMO;
          change_d = credit_q;
          credit_d = '0;
          state_d  = CHANGE;
        end else tmo_d = tmo_q + 1'b1;
      VEND:
        if (vend_ack) begin
          credit_d = '0;
          state_d  = change_q != 8'd0 ? CHANGE : COLLECT;
        end
      CHANGE:
        if (change_ack) begin
          change_d = change_q - pay_val;
          credit_d = '0;
          state_d  = change_q == pay_val ? COLLECT : CHANGE;
        end
      default: state_d = COLLECT;
    endcase
  end
endmodule
